flag_unit: RTL and testbench

Parametrised NZCV status-flag unit for the datapath: computes N, Z, C and V from an ALU operation of configurable width and holds them in a flag register with per-flag write masking. A small LIFO of saved flag words supports interrupt entry and exit. A registered-flag condition evaluator serves branch logic. It sits between the ALU/shifter outputs and the control unit, and replaces the earlier purely combinational N/Z-only generator.

---
 rtl/flag_pkg.sv | 76 +++++++
 rtl/flag_stack.sv | 94 +++++++++
 rtl/flag_unit.sv | 126 ++++++++++++
 tb/tb_flag_unit.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flag_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : flag_pkg
//  Purpose  : Shared definitions for the NZCV flag unit. Holds the operation
//             class codes, flag bit positions, ARM condition codes, the reset
//             flag word, and the condition evaluator used for branches.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package flag_pkg;

  // Operation classes driven by the ALU/shifter on op_class
  localparam logic [1:0] OP_LOGIC = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;
  localparam logic [1:0] OP_SHIFT = 2'b11;

  // Bit positions inside the {N,Z,C,V} flag word
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // ARM condition-code encoding
  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

  // Flag word after reset: only Z set
  localparam logic [3:0] FLAGS_RESET = 4'b0100;

  // Evaluate a condition code against a {N,Z,C,V} word
  function automatic logic condEval(input logic [3:0] f, input logic [3:0] c);
    logic n, z, cy, v, res;
    n   = f[FLAG_N];
    z   = f[FLAG_Z];
    cy  = f[FLAG_C];
    v   = f[FLAG_V];
    res = 1'b0;
    case (c)
      COND_EQ: res = z;
      COND_NE: res = !z;
      COND_CS: res = cy;
      COND_CC: res = !cy;
      COND_MI: res = n;
      COND_PL: res = !n;
      COND_VS: res = v;
      COND_VC: res = !v;
      COND_HI: res = cy && !z;
      COND_LS: res = !cy || z;
      COND_GE: res = (n == v);
      COND_LT: res = (n != v);
      COND_GT: res = !z && (n == v);
      COND_LE: res = z || (n != v);
      COND_AL: res = 1'b1;
      COND_NV: res = 1'b0;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/flag_stack.sv
`default_nettype none
// ============================================================================
//  Module   : flag_stack
//  Purpose  : LIFO of 4-bit flag words used to save/restore flags around
//             interrupts. Simultaneous push and pop, push when full and pop
//             when empty are all ignored and raise a one-cycle err pulse.
//  Ports    : clk, reset (async, active-low)
//             push, pop       - stack requests
//             pushData        - word stored on a legal push
//             popData         - current top-of-stack word
//             popOk           - a legal pop happens this cycle (combinational)
//             empty, full     - registered status
//             err             - registered one-cycle illegal-operation pulse
//  Revision : 1.0 - initial release
// ============================================================================
module flag_stack
  import flag_pkg::*;
#(
  parameter int STACK_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [3:0] pushData,
  output logic [3:0] popData,
  output logic       popOk,
  output logic       empty,
  output logic       full,
  output logic       err
);

  localparam int PTR_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptrNext;
  logic [3:0]       r_mem [STACK_DEPTH];
  logic             r_empty;
  logic             r_full;
  logic             r_err;
  logic             w_pushOk;
  logic             w_popOk;
  logic             w_err;
  logic [IDX_W-1:0] w_topIdx;
  logic [IDX_W-1:0] w_wrIdx;

  // A push/pop collision cancels both, so each side is only legal alone
  assign w_pushOk = push && !pop && !r_full;
  assign w_popOk  = pop && !push && !r_empty;
  assign w_err    = (push && pop) || (push && r_full) || (pop && r_empty);

  always_comb begin
    w_ptrNext = r_ptr;
    if (w_pushOk) begin
      w_ptrNext = r_ptr + PTR_W'(1);
    end else if (w_popOk) begin
      w_ptrNext = r_ptr - PTR_W'(1);
    end
  end

  assign w_topIdx = IDX_W'(r_ptr - PTR_W'(1));
  assign w_wrIdx  = IDX_W'(r_ptr);

  // Status flags are registered from the next pointer so they line up with it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr   <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ptr   <= w_ptrNext;
      r_empty <= (w_ptrNext == '0);
      r_full  <= (w_ptrNext == PTR_W'(STACK_DEPTH));
      r_err   <= w_err;
    end
  end

  // Storage needs no reset: contents are meaningless while the pointer is 0
  always_ff @(posedge clk) begin
    if (w_pushOk) begin
      r_mem[w_wrIdx] <= pushData;
    end
  end

  assign popData = r_empty ? 4'b0000 : r_mem[w_topIdx];
  assign popOk   = w_popOk;
  assign empty   = r_empty;
  assign full    = r_full;
  assign err     = r_err;

endmodule
`default_nettype wire

// File: rtl/flag_unit.sv
`default_nettype none
// ============================================================================
//  Module   : flag_unit
//  Purpose  : NZCV status-flag unit. Builds candidate flags from an ALU
//             operation, applies per-flag masking, arbitrates between stack
//             restore / direct write / ALU update, holds the flag register
//             and evaluates branch conditions from the registered flags.
//  Ports    : clk, reset (async, active-low)
//             upd_valid, upd_mask, op_class, opa, opb, result, shift_carry
//                         - ALU flag update request and its operands
//             wr_valid, wr_flags - direct flag write
//             push, pop   - save/restore flags on the internal stack
//             cond        - condition code; cond_true is its result
//             flags       - registered {N,Z,C,V}
//             stack_empty, stack_full, stack_err - stack status
//  Revision : 1.0 - initial release
// ============================================================================
module flag_unit
  import flag_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             upd_valid,
  input  logic [3:0]       upd_mask,
  input  logic [1:0]       op_class,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic [WIDTH-1:0] result,
  input  logic             shift_carry,
  input  logic             wr_valid,
  input  logic [3:0]       wr_flags,
  input  logic             push,
  input  logic             pop,
  input  logic [3:0]       cond,
  output logic [3:0]       flags,
  output logic             cond_true,
  output logic             stack_empty,
  output logic             stack_full,
  output logic             stack_err
);

  localparam int MSB = WIDTH - 1;

  logic [3:0] r_flags;
  logic [3:0] w_cand;
  logic [3:0] w_effMask;
  logic [3:0] w_updFlags;
  logic [3:0] w_flagsNext;
  logic [3:0] w_popData;
  logic       w_popOk;
  logic       w_addCarry;

  // opa + opb overflows WIDTH bits exactly when opa > (2^WIDTH-1 - opb) = ~opb
  assign w_addCarry = (opa > ~opb);

  always_comb begin
    w_cand         = r_flags;
    w_effMask      = upd_mask;
    w_cand[FLAG_N] = result[MSB];
    w_cand[FLAG_Z] = (result == '0);
    case (op_class)
      OP_ADD: begin
        w_cand[FLAG_C] = w_addCarry;
        w_cand[FLAG_V] = (opa[MSB] == opb[MSB]) && (result[MSB] != opa[MSB]);
      end
      OP_SUB: begin
        w_cand[FLAG_C] = (opa >= opb);
        w_cand[FLAG_V] = (opa[MSB] != opb[MSB]) && (result[MSB] != opa[MSB]);
      end
      OP_SHIFT: begin
        w_cand[FLAG_C] = shift_carry;
      end
      default: begin
        // Logic ops never touch C/V, whatever the mask says
        w_effMask[FLAG_C] = 1'b0;
        w_effMask[FLAG_V] = 1'b0;
      end
    endcase
  end

  assign w_updFlags = (w_effMask & w_cand) | (~w_effMask & r_flags);

  // Restore beats direct write beats ALU update
  always_comb begin
    w_flagsNext = r_flags;
    if (w_popOk) begin
      w_flagsNext = w_popData;
    end else if (wr_valid) begin
      w_flagsNext = wr_flags;
    end else if (upd_valid) begin
      w_flagsNext = w_updFlags;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flags <= FLAGS_RESET;
    end else begin
      r_flags <= w_flagsNext;
    end
  end

  // Stack saves the pre-update flag word
  flag_stack #(
    .STACK_DEPTH(STACK_DEPTH)
  ) u_stack (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .pushData(r_flags),
    .popData (w_popData),
    .popOk   (w_popOk),
    .empty   (stack_empty),
    .full    (stack_full),
    .err     (stack_err)
  );

  assign flags     = r_flags;
  assign cond_true = condEval(r_flags, cond);

endmodule
`default_nettype wire

// File: tb/tb_flag_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_flag_unit
//  Purpose  : Self-checking bench for flag_unit (WIDTH=8, STACK_DEPTH=4).
//             Table of ALU-update vectors plus directed stack/reset sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_flag_unit;

  localparam int WIDTH       = 8;
  localparam int STACK_DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             upd_valid;
  logic [3:0]       upd_mask;
  logic [1:0]       op_class;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] result;
  logic             shift_carry;
  logic             wr_valid;
  logic [3:0]       wr_flags;
  logic             push;
  logic             pop;
  logic [3:0]       cond;
  logic [3:0]       flags;
  logic             cond_true;
  logic             stack_empty;
  logic             stack_full;
  logic             stack_err;

  int nChecks = 0;
  int nFail   = 0;

  flag_unit #(
    .WIDTH(WIDTH),
    .STACK_DEPTH(STACK_DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .upd_valid  (upd_valid),
    .upd_mask   (upd_mask),
    .op_class   (op_class),
    .opa        (opa),
    .opb        (opb),
    .result     (result),
    .shift_carry(shift_carry),
    .wr_valid   (wr_valid),
    .wr_flags   (wr_flags),
    .push       (push),
    .pop        (pop),
    .cond       (cond),
    .flags      (flags),
    .cond_true  (cond_true),
    .stack_empty(stack_empty),
    .stack_full (stack_full),
    .stack_err  (stack_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] pre;
    logic [1:0] cls;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic       sc;
    logic [3:0] mask;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference condition table written from the ARM definitions
  function automatic logic refCond(input logic [3:0] f, input logic [3:0] c);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return ~z;
      4'd2:  return cy;
      4'd3:  return ~cy;
      4'd4:  return n;
      4'd5:  return ~n;
      4'd6:  return v;
      4'd7:  return ~v;
      4'd8:  return cy & ~z;
      4'd9:  return ~cy | z;
      4'd10: return ~(n ^ v);
      4'd11: return n ^ v;
      4'd12: return ~z & ~(n ^ v);
      4'd13: return z | (n ^ v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic idle();
    upd_valid   = 1'b0;
    upd_mask    = 4'b0000;
    op_class    = 2'b00;
    opa         = '0;
    opb         = '0;
    result      = '0;
    shift_carry = 1'b0;
    wr_valid    = 1'b0;
    wr_flags    = 4'b0000;
    push        = 1'b0;
    pop         = 1'b0;
  endtask

  // Inputs are driven and outputs sampled on the falling edge
  task automatic writeFlags(input logic [3:0] v);
    wr_valid = 1'b1;
    wr_flags = v;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  logic [3:0] pv[5];

  initial begin
    idle();
    cond  = 4'd0;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("reset_flags", flags, 4'b0100);
    check("reset_empty", stack_empty, 1'b1);
    check("reset_full", stack_full, 1'b0);
    check("reset_err", stack_err, 1'b0);
    check("reset_eq", cond_true, 1'b1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    //            pre      cls    a      b      r      sc    mask     exp
    vecs[0]  = '{4'b0000, 2'b01, 8'h7F, 8'h01, 8'h80, 1'b0, 4'b1111, 4'b1001};
    vecs[1]  = '{4'b0000, 2'b10, 8'h05, 8'h05, 8'h00, 1'b0, 4'b1111, 4'b0110};
    vecs[2]  = '{4'b0011, 2'b00, 8'h00, 8'h00, 8'h00, 1'b0, 4'b1111, 4'b0111};
    vecs[3]  = '{4'b0000, 2'b01, 8'hFF, 8'h01, 8'h00, 1'b0, 4'b1111, 4'b0110};
    vecs[4]  = '{4'b0000, 2'b10, 8'h03, 8'h05, 8'hFE, 1'b0, 4'b1111, 4'b1000};
    vecs[5]  = '{4'b0000, 2'b10, 8'h80, 8'h01, 8'h7F, 1'b0, 4'b1111, 4'b0011};
    vecs[6]  = '{4'b0001, 2'b11, 8'h00, 8'h00, 8'h00, 1'b1, 4'b1111, 4'b0111};
    vecs[7]  = '{4'b1111, 2'b11, 8'h00, 8'h00, 8'h40, 1'b0, 4'b1111, 4'b0001};
    vecs[8]  = '{4'b0000, 2'b01, 8'h7F, 8'h01, 8'h80, 1'b0, 4'b1000, 4'b1000};
    vecs[9]  = '{4'b1010, 2'b01, 8'h00, 8'h00, 8'h00, 1'b0, 4'b0000, 4'b1010};
    vecs[10] = '{4'b0000, 2'b00, 8'h00, 8'h00, 8'h80, 1'b0, 4'b0011, 4'b0000};
    vecs[11] = '{4'b1010, 2'b01, 8'h80, 8'h80, 8'h00, 1'b0, 4'b0101, 4'b1111};

    for (int i = 0; i < 12; i++) begin
      writeFlags(vecs[i].pre);
      upd_valid   = 1'b1;
      op_class    = vecs[i].cls;
      opa         = vecs[i].a;
      opb         = vecs[i].b;
      result      = vecs[i].r;
      shift_carry = vecs[i].sc;
      upd_mask    = vecs[i].mask;
      @(negedge clk);
      idle();
      check($sformatf("vec%0d_flags", i), flags, vecs[i].exp);
      for (int c = 0; c < 16; c++) begin
        cond = 4'(c);
        #1;
        check($sformatf("vec%0d_cond%0d", i, c), cond_true, refCond(vecs[i].exp, 4'(c)));
      end
      @(negedge clk);
    end

    // Fill the stack past full, then drain it past empty
    pv = '{4'b0001, 4'b0010, 4'b1000, 4'b1011, 4'b1110};
    for (int i = 0; i < 5; i++) begin
      writeFlags(pv[i]);
      push = 1'b1;
      @(negedge clk);
      push = 1'b0;
      check($sformatf("push%0d_full", i), stack_full, (i >= 3) ? 1'b1 : 1'b0);
      check($sformatf("push%0d_err", i), stack_err, (i == 4) ? 1'b1 : 1'b0);
      check($sformatf("push%0d_empty", i), stack_empty, 1'b0);
    end
    @(negedge clk);
    check("push_err_pulse_end", stack_err, 1'b0);
    check("flags_after_pushes", flags, pv[4]);

    for (int i = 0; i < 5; i++) begin
      pop = 1'b1;
      @(negedge clk);
      pop = 1'b0;
      check($sformatf("pop%0d_flags", i), flags, (i < 4) ? pv[3-i] : pv[0]);
      check($sformatf("pop%0d_err", i), stack_err, (i == 4) ? 1'b1 : 1'b0);
      check($sformatf("pop%0d_empty", i), stack_empty, (i >= 3) ? 1'b1 : 1'b0);
      check($sformatf("pop%0d_full", i), stack_full, 1'b0);
    end
    @(negedge clk);
    check("pop_err_pulse_end", stack_err, 1'b0);

    // Push alongside an ALU update: old flags saved, new flags registered
    push      = 1'b1;
    upd_valid = 1'b1;
    op_class  = 2'b01;
    opa       = 8'h7F;
    opb       = 8'h01;
    result    = 8'h80;
    upd_mask  = 4'b1111;
    @(negedge clk);
    idle();
    check("push_upd_flags", flags, 4'b1001);
    check("push_upd_empty", stack_empty, 1'b0);
    pop = 1'b1;
    @(negedge clk);
    pop = 1'b0;
    check("push_upd_restore", flags, 4'b0001);
    check("push_upd_empty2", stack_empty, 1'b1);

    // Pop alongside a direct write: popped value wins
    writeFlags(4'b1100);
    push = 1'b1;
    @(negedge clk);
    push = 1'b0;
    writeFlags(4'b0011);
    pop      = 1'b1;
    wr_valid = 1'b1;
    wr_flags = 4'b0110;
    @(negedge clk);
    idle();
    check("pop_wr_flags", flags, 4'b1100);
    check("pop_wr_err", stack_err, 1'b0);

    // Pop on empty with a direct write: write proceeds, error pulses
    pop      = 1'b1;
    wr_valid = 1'b1;
    wr_flags = 4'b1010;
    @(negedge clk);
    idle();
    check("pop_empty_wr_flags", flags, 4'b1010);
    check("pop_empty_wr_err", stack_err, 1'b1);
    check("pop_empty_wr_empty", stack_empty, 1'b1);

    // Push+pop collision with a logic update: update proceeds, stack untouched
    push      = 1'b1;
    pop       = 1'b1;
    upd_valid = 1'b1;
    op_class  = 2'b00;
    result    = 8'h00;
    upd_mask  = 4'b1111;
    @(negedge clk);
    idle();
    check("collide_flags", flags, 4'b0110);
    check("collide_err", stack_err, 1'b1);
    check("collide_empty", stack_empty, 1'b1);

    // Asynchronous reset mid-stream with two entries pushed
    push = 1'b1;
    @(negedge clk);
    @(negedge clk);
    push = 1'b0;
    check("pre_reset_empty", stack_empty, 1'b0);
    check("pre_reset_flags", flags, 4'b0110);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_reset_flags", flags, 4'b0100);
    check("async_reset_empty", stack_empty, 1'b1);
    check("async_reset_full", stack_full, 1'b0);
    check("async_reset_err", stack_err, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_reset_flags", flags, 4'b0100);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
`default_nettype wire
